// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial frame transmitter (and future receiver).
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Parallel load handshake and serial line status bundle for serial_frame_tx.
interface serial_frame_tx_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic [DATA_W-1:0] pIn;
    logic              load;
    logic              ready;
    logic              sOut;
    logic              busy;
    logic              done;

    modport master (
        output pIn,
        output load,
        input  ready,
        input  sOut,
        input  busy,
        input  done
    );

    modport slave (
        input  pIn,
        input  load,
        output ready,
        output sOut,
        output busy,
        output done
    );

endinterface

// File: rtl/bit_timer.sv
// Per-bit cycle counter; tick marks the last cycle of each bit slot.
module bit_timer #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // With BIT_CYCLES==1 the counter stays at 0 and tick is permanently high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == TERM);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, data LSB first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    serial_frame_tx_if.slave bus
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_sout;
    logic              r_busy;

    tx_state_t         w_state_next;
    logic [DATA_W-1:0] w_shreg_next;
    logic [IDX_W-1:0]  w_bit_idx_next;
    logic              w_sout_next;
    logic              w_busy_next;
    logic              w_tick;
    logic              w_timer_clr;
    logic              w_ready;
    logic              w_done;
    logic              w_accept;
    logic              w_last_bit;

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_timer_clr),
        .tick (w_tick)
    );

    // Ready opens in the last stop cycle so frames can run back to back.
    assign w_ready     = (r_state == IDLE) || ((r_state == STOP) && w_tick);
    assign w_done      = (r_state == STOP) && w_tick;
    assign w_accept    = bus.load && w_ready;
    assign w_last_bit  = (r_bit_idx == LAST_IDX);
    assign w_timer_clr = (r_state == IDLE) || w_accept;

`ifdef SERIAL_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^bus.pIn;
        end
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_sout    <= LINE_IDLE;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shreg   <= w_shreg_next;
            r_bit_idx <= w_bit_idx_next;
            r_sout    <= w_sout_next;
            r_busy    <= w_busy_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (w_accept) w_state_next = START;
            START:  if (w_tick) w_state_next = DATA;
            DATA: begin
                if (w_tick && w_last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (w_tick) w_state_next = STOP;
`endif
            STOP:   if (w_tick) w_state_next = w_accept ? START : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Next values of the registered line, busy flag, shift register and bit index.
    always_comb begin
        w_shreg_next   = r_shreg;
        w_bit_idx_next = r_bit_idx;
        w_sout_next    = LINE_IDLE;
        w_busy_next    = (w_state_next != IDLE);

        if (w_accept) begin
            w_shreg_next   = bus.pIn;
            w_bit_idx_next = '0;
        end else if ((r_state == DATA) && w_tick) begin
            w_shreg_next   = r_shreg >> 1;
            w_bit_idx_next = w_last_bit ? '0 : r_bit_idx + IDX_W'(1);
        end

        case (w_state_next)
            START:  w_sout_next = START_BIT;
            DATA:   w_sout_next = w_shreg_next[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: w_sout_next = r_parity;
`endif
            STOP:   w_sout_next = STOP_BIT;
            default: w_sout_next = LINE_IDLE;
        endcase
    end

    assign bus.ready = w_ready;
    assign bus.done  = w_done;
    assign bus.sOut  = r_sout;
    assign bus.busy  = r_busy;

endmodule
